// File: rtl/mul_hilo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_hilo_ctrl: sequencer for the shared Booth multiplier and HI/LO owner.  |
// | Optional: MUL_CTRL_ZERO_BYPASS_EN (zero-operand requests skip the core).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mul_hilo_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_signed,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    input  logic [1:0]  hilo_we,
    input  logic [31:0] hilo_wdata,
    output logic        busy,
    output logic        done_pulse,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_rst_n,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_done,
    input  logic [63:0] mul_c
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_FIX   = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic        r_live;
    logic        r_signed;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_prod;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_accept;
    logic        w_zero;
    logic        w_abort;
    logic        w_commit;
    logic [63:0] w_corr;
    logic [63:0] w_fixed;

    // r_live holds req_ready low until the first edge after reset release.
    assign w_accept = r_live & (r_state == c_ST_IDLE) & req_valid & ~flush;
    assign w_abort  = flush & (r_state != c_ST_IDLE);
    assign w_commit = (r_state == c_ST_FIX) & ~flush;

`ifdef MUL_CTRL_ZERO_BYPASS_EN
    assign w_zero = (req_a == 32'd0) | (req_b == 32'd0);
`else
    assign w_zero = 1'b0;
`endif

    // Signed core product turned into the unsigned one by adding back the
    // cross terms the sign bits removed.
    assign w_corr  = (r_a[31] ? {r_b, 32'd0} : 64'd0) + (r_b[31] ? {r_a, 32'd0} : 64'd0);
    assign w_fixed = r_signed ? r_prod : (r_prod + w_corr);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept) w_next = w_zero ? c_ST_FIX : c_ST_START;
            c_ST_START: w_next = c_ST_WAIT;
            c_ST_WAIT:  if (mul_done) w_next = c_ST_FIX;
            c_ST_FIX:   w_next = c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
        if (w_abort) w_next = c_ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_ST_IDLE;
            r_live   <= 1'b0;
            r_signed <= 1'b0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_prod   <= 64'd0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            r_done  <= w_commit;
            if (w_accept) begin
                r_a      <= req_a;
                r_b      <= req_b;
                r_signed <= req_signed;
            end
            if (w_accept & w_zero) begin
                r_prod <= 64'd0;
            end else if ((r_state == c_ST_WAIT) & mul_done) begin
                r_prod <= mul_c;
            end
        end
    end

    // A product commit overrides a coincident MTHI/MTLO on both halves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            r_hi <= w_fixed[63:32];
            r_lo <= w_fixed[31:0];
        end else begin
            if (hilo_we[1]) r_hi <= hilo_wdata;
            if (hilo_we[0]) r_lo <= hilo_wdata;
        end
    end

    assign req_ready  = r_live & (r_state == c_ST_IDLE);
    assign busy       = (r_state != c_ST_IDLE);
    assign done_pulse = r_done;
    assign hi         = r_hi;
    assign lo         = r_lo;
    assign mul_a      = r_a;
    assign mul_b      = r_b;
    // Core is held in Init during reset, START, and any aborted cycle.
    assign mul_rst_n  = r_live & (r_state != c_ST_START) & ~w_abort;

endmodule
`default_nettype wire

// File: tb/tb_mul_hilo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mul_hilo_ctrl: scoreboard bench with a behavioural multiplier core.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mul_hilo_ctrl;

    localparam int c_LAT = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_signed = 1'b0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        flush = 1'b0;
    logic [1:0]  hilo_we = 2'b00;
    logic [31:0] hilo_wdata = 32'd0;
    logic        busy;
    logic        done_pulse;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mul_rst_n;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_done = 1'b0;
    logic [63:0] mul_c = 64'd0;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    mul_hilo_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_signed(req_signed), .req_a(req_a), .req_b(req_b), .flush(flush),
        .hilo_we(hilo_we), .hilo_wdata(hilo_wdata), .busy(busy),
        .done_pulse(done_pulse), .hi(hi), .lo(lo), .mul_rst_n(mul_rst_n),
        .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_c(mul_c)
    );

    always #5 clk = ~clk;

    // Core model: done appears in the c_LAT-th cycle after restart and stays
    // high (stale) until the next restart; mul_c is junk until done.
    int core_cnt = 0;
    always @(posedge clk) begin
        if (!mul_rst_n) begin
            core_cnt <= 0;
            mul_done <= 1'b0;
            mul_c    <= {$urandom, $urandom};
        end else if (!mul_done) begin
            if (core_cnt == c_LAT - 2) begin
                mul_done <= 1'b1;
                mul_c    <= 64'(longint'($signed(mul_a)) * longint'($signed(mul_b)));
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end

    function automatic logic [63:0] ref_prod(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua;
        longint unsigned ub;
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done_pulse must match the oldest outstanding product.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (rst && done_pulse) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got hilo %h expected no pulse", {hi, lo});
            end else begin
                exp = sb_q.pop_front();
                if ({hi, lo} !== exp) begin
                    errors++;
                    $display("FAIL scoreboard: got %h expected %h", {hi, lo}, exp);
                end
            end
        end
    end

    // Called just after a negedge; returns 1 ns after the accepting posedge.
    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, input bit push);
        int n = 0;
        req_valid  = 1'b1;
        req_signed = s;
        req_a      = a;
        req_b      = b;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 64'(n), 64'd0);
        @(posedge clk);
        if (push) sb_q.push_back(ref_prod(s, a, b));
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt, output int rlow);
        lat = 0; bcnt = 0; rlow = 0;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (!mul_rst_n) rlow++;
            if (done_pulse) break;
            if (busy) bcnt++;
        end
        if (!done_pulse) chk("done_timeout", 64'(lat), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, bc, rl, n;
        logic [31:0] ra, rb;
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_mul_rst_n", 64'(mul_rst_n), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_done", 64'(done_pulse), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'd1);
        chk("busy_after_rst", 64'(busy), 64'd0);

        // MULT -1 x 5: full latency, busy only during the op
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1);
        wait_done(lat, bc, rl);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFB);
        chk("mult_lat", 64'(lat), 64'(c_LAT + 3));
        chk("mult_busy_cycles", 64'(bc), 64'(c_LAT + 2));
        chk("busy_low_at_done", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);

        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat, bc, rl);
        chk("multu_ff", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        issue(1'b0, 32'h8000_0000, 32'h0000_0002, 1'b1);
        wait_done(lat, bc, rl);
        chk("multu_8x2", {hi, lo}, 64'h0000_0001_0000_0000);

        // Flush 10 cycles into WAIT
        @(negedge clk);
        hilo_we = 2'b10; hilo_wdata = 32'h1234_5678;
        @(negedge clk);
        hilo_we = 2'b01; hilo_wdata = 32'h9ABC_DEF0;
        @(negedge clk);
        hilo_we = 2'b00;
        chk("mthi_mtlo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        issue(1'b1, 32'd7, 32'd9, 1'b0);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_mul_rst_n", 64'(mul_rst_n), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle_busy", 64'(busy), 64'd0);
        chk("flush_idle_ready", 64'(req_ready), 64'd1);
        chk("flush_hilo_kept", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        repeat (50) @(negedge clk);
        issue(1'b1, 32'd3, 32'd4, 1'b1);
        wait_done(lat, bc, rl);
        chk("mult_3x4", {hi, lo}, 64'd12);

        // MTHI mid-WAIT, then MTLO colliding with the FIX commit
        @(negedge clk);
        ra = 32'h1357_9BDF; rb = 32'h8642_0ECA;
        issue(1'b0, ra, rb, 1'b1);
        repeat (5) @(negedge clk);
        hilo_we = 2'b10; hilo_wdata = 32'hAAAA_0000;
        @(negedge clk);
        hilo_we = 2'b00;
        chk("mthi_in_wait", {hi, lo}, {32'hAAAA_0000, 32'd12});
        n = 0;
        while (!(busy && mul_done) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        hilo_we = 2'b01; hilo_wdata = 32'h5555_5555;
        @(negedge clk);
        hilo_we = 2'b00;
        chk("fix_commit_wins", {64'(done_pulse), {hi, lo}}, {64'd1, ref_prod(1'b0, ra, rb)});
        repeat (2) @(negedge clk);

        // Zero operand: bypass or full core latency depending on build
        issue(1'b1, 32'd0, 32'h7FFF_FFFF, 1'b1);
        wait_done(lat, bc, rl);
        chk("zero_hilo", {hi, lo}, 64'd0);
`ifdef MUL_CTRL_ZERO_BYPASS_EN
        chk("zero_lat", 64'(lat), 64'd2);
        chk("zero_no_core_rst", 64'(rl), 64'd0);
`else
        chk("zero_lat", 64'(lat), 64'(c_LAT + 3));
        chk("zero_core_rst", 64'(rl), 64'd1);
`endif

        // Randomized back-to-back requests, held while busy
        for (int i = 0; i < 24; i++) begin
            issue(1'($urandom), pick(), pick(), 1'b1);
            @(negedge clk);
        end
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        // Reset mid-operation abandons the op
        issue(1'b0, 32'd5, 32'd6, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_mul_rst_n", 64'(mul_rst_n), 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(req_ready), 64'd1);
        repeat (50) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mul_hilo_ctrl.md
# mul_hilo_ctrl

Sequencer and HI/LO owner for the CPU's shared 32-bit iterative Booth multiplier. It accepts MULT/MULTU requests from the EX stage over a valid/ready handshake, restarts and monitors the multiplier core, and applies the unsigned correction for MULTU. It commits the 64-bit product into the architectural HI/LO registers and services MTHI/MTLO writes. Pipeline flush cancels an operation in flight.

## Interface
Parameters:
- none; data width fixed at 32, product width 64.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  multiply request from EX
- req_ready  out  1  controller can accept a request
- req_signed  in  1  1 = MULT, 0 = MULTU
- req_a, req_b  in  32  operands rs, rt
- flush  in  1  cancel in-flight op; HI/LO left unchanged
- hilo_we  in  2  bit1 = MTHI, bit0 = MTLO
- hilo_wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in flight; EX stalls on MFHI/MFLO/mult while high
- done_pulse  out  1  one-cycle pulse when HI/LO committed from a product
- hi, lo  out  32  architectural HI/LO
- mul_rst_n  out  1  restart to multiplier core, active-low
- mul_a, mul_b  out  32  operands to core
- mul_done  in  1  core finished
- mul_c  in  64  core signed product

## Operation
- States: IDLE, START, WAIT, FIX.
- IDLE:
  - req_ready=1, busy=0.
  - req_valid & !flush: latch req_a, req_b, req_signed; go to START.
- START:
  - mul_rst_n=0 for exactly one cycle, which puts the core in Init with done=0.
  - Go to WAIT.
- WAIT: mul_rst_n=1; on mul_done=1, capture mul_c into a 64-bit product register; go to FIX.
- FIX:
  - For unsigned ops, p = mul_c + (a[31] ? b<<32 : 0) + (b[31] ? a<<32 : 0), mod 2^64. Signed ops use mul_c unchanged.
  - {hi,lo} <= p; done_pulse=1; go to IDLE.
- mul_a and mul_b hold the latched operands from START until IDLE; the core samples them combinationally.
- busy=1 in START, WAIT and FIX; req_ready=0 there. A req_valid while busy is not accepted and must be held by EX.
- flush in START, WAIT or FIX: go to IDLE next cycle, no HI/LO write, no done_pulse. mul_rst_n is driven low during that cycle so the core idles.
- flush and req_valid together in IDLE: request rejected.
- hilo_we:
  - Applies in any state, next edge, per bit.
  - If it coincides with the FIX commit, the commit wins for both HI and LO.
- Reset:
  - state=IDLE, hi=lo=0, mul_rst_n=0, done_pulse=0, busy=0, req_ready=0.
  - req_ready is 1 from the first edge after release.
  - Reset mid-operation abandons the op.

## Timing
- Accept edge → START 1 cycle → WAIT (core latency, 34 cycles with the standard core) → FIX 1 cycle.
- done_pulse and new hi/lo are visible the cycle after FIX.
- Back-to-back: the next request is accepted in the IDLE cycle following FIX, so no dead cycle is added beyond IDLE.
- hi/lo are registered outputs with no combinational path from inputs.
- mul_done is only sampled in WAIT; a stale high in any other state is ignored.

## Configuration
- MUL_CTRL_ZERO_BYPASS_EN:
  - Defined: in IDLE, an accepted request with req_a==0 or req_b==0 skips START/WAIT and goes straight to FIX with p=0, giving 2-cycle latency; the core is never restarted.
  - Undefined: all requests go through the core.

## Test plan
- Reset release → hi=lo=0, busy=0, req_ready=1 by cycle 1; mul_rst_n low while rst low.
- MULT a=0xFFFFFFFF (−1), b=0x00000005 → {hi,lo}=0xFFFFFFFF_FFFFFFFB, one done_pulse, busy high through the operation only.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → {hi,lo}=0xFFFFFFFE_00000001; MULTU 0x80000000×2 → 0x00000001_00000000.
- flush asserted 10 cycles into WAIT → back in IDLE next cycle, HI/LO keep prior 0x12345678/0x9ABCDEF0, no done_pulse. A following MULT 3×4 gives lo=12, hi=0.
- MTHI 0xAAAA0000 during WAIT → hi updates immediately. MTLO in the same cycle as FIX → product wins.
- With MUL_CTRL_ZERO_BYPASS_EN, MULT 0×0x7FFFFFFF → lo=hi=0 two cycles after accept, mul_rst_n never pulsed. Without the macro, the same request takes full core latency.
